// File: rtl/im_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words, writes them to consecutive word addresses and holds the CPU meanwhile.

module im_loader_checker (
    input logic clk,
    input logic rst,
    input logic we,
    input logic byte_ready,
    input logic busy,
    input logic done,
    input logic err,
    input logic cpu_hold
);

    a_we_single_cycle: assert property (@(posedge clk) disable iff (!rst)
        we |=> !we);

    a_no_ready_during_write: assert property (@(posedge clk) disable iff (!rst)
        we |-> !byte_ready);

    a_ready_only_when_busy: assert property (@(posedge clk) disable iff (!rst)
        byte_ready |-> busy);

    a_busy_holds_cpu: assert property (@(posedge clk) disable iff (!rst)
        busy |-> cpu_hold);

    a_done_releases_cpu: assert property (@(posedge clk) disable iff (!rst)
        done |-> (!cpu_hold && !busy && !err));

endmodule

module im_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A legal length is 1 .. 2^ADDR_W words (top bit set only for exactly 2^ADDR_W).
    function automatic logic len_legal(input logic [ADDR_W:0] len);
        logic nonzero;
        logic in_range;
        nonzero  = (len != {(ADDR_W+1){1'b0}});
        in_range = (len[ADDR_W] == 1'b0) || (len[ADDR_W-1:0] == {ADDR_W{1'b0}});
        return nonzero && in_range;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   word_cnt_r;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       asm_r;
    logic              byte_ready_r;
    logic              we_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [31:0]       wdata_r;
    logic              cpu_hold_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic accept_s;
    logic start_ok_s;
    logic start_bad_s;
    logic last_word_s;

    assign accept_s    = byte_valid && byte_ready_r;
    assign start_ok_s  = start && len_legal(len_words);
    assign start_bad_s = start && !len_legal(len_words);
    assign last_word_s = ((word_cnt_r + {{ADDR_W{1'b0}}, 1'b1}) == len_r);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = RECV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RECV: begin
                if (accept_s && (byte_cnt_r == 2'd3)) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = RECV;
                end
            end
            WRITE: begin
                if (last_word_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RECV;
                end
            end
            DONE: begin
                if (start_ok_s) begin
                    state_nxt_s = RECV;
                end else if (start_bad_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Length, counters, word assembly and the latched write address/data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_r      <= {(ADDR_W+1){1'b0}};
            word_cnt_r <= {(ADDR_W+1){1'b0}};
            byte_cnt_r <= 2'd0;
            asm_r      <= 24'd0;
            waddr_r    <= {ADDR_W{1'b0}};
            wdata_r    <= 32'd0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start_ok_s) begin
                        len_r      <= len_words;
                        word_cnt_r <= {(ADDR_W+1){1'b0}};
                        byte_cnt_r <= 2'd0;
                        asm_r      <= 24'd0;
                        err_r      <= 1'b0;
                    end else if (start_bad_s) begin
                        err_r <= 1'b1;
                    end
                end
                RECV: begin
                    if (accept_s) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        case (byte_cnt_r)
                            2'd0: asm_r[7:0]   <= byte_data;
                            2'd1: asm_r[15:8]  <= byte_data;
                            2'd2: asm_r[23:16] <= byte_data;
                            2'd3: begin
                                // Completed word is presented on the very next cycle.
                                wdata_r <= {byte_data, asm_r};
                                waddr_r <= word_cnt_r[ADDR_W-1:0];
                            end
                            default: asm_r <= asm_r;
                        endcase
                    end
                end
                WRITE: begin
                    if (!last_word_s) begin
                        word_cnt_r <= word_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
                    end
                end
                default: begin
                    byte_cnt_r <= byte_cnt_r;
                end
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_ready_r <= 1'b0;
            we_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            cpu_hold_r   <= 1'b1;
        end else begin
            byte_ready_r <= (state_nxt_s == RECV);
            we_r         <= (state_nxt_s == WRITE);
            busy_r       <= (state_nxt_s == RECV) || (state_nxt_s == WRITE);
            done_r       <= (state_nxt_s == DONE);
            cpu_hold_r   <= (state_nxt_s != DONE);
        end
    end

    assign byte_ready = byte_ready_r;
    assign we         = we_r;
    assign waddr      = waddr_r;
    assign wdata      = wdata_r;
    assign cpu_hold   = cpu_hold_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

    im_loader_checker u_chk (
        .clk        (clk),
        .rst        (rst),
        .we         (we_r),
        .byte_ready (byte_ready_r),
        .busy       (busy_r),
        .done       (done_r),
        .err        (err_r),
        .cpu_hold   (cpu_hold_r)
    );

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: a byte driver feeds a queue, a monitor
// compares every write strobe against the expected-write queue.

module tb_im_loader;

    localparam int ADDR_W = 10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   len_words;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    wr_t        mon_e;
    int         checks = 0;
    int         errors = 0;
    int         we_cnt = 0;
    bit         toggle_mode = 1'b0;
    bit         phase = 1'b0;
    bit         acc_pend = 1'b0;

    im_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len_words  (len_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        tx_q.push_back(b0);
        tx_q.push_back(b1);
        tx_q.push_back(b2);
        tx_q.push_back(b3);
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [ADDR_W:0] len);
        @(negedge clk);
        start     = 1'b1;
        len_words = len;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int cyc, output logic prev_we);
        cyc     = 0;
        prev_we = 1'b0;
        while (!done && cyc < maxc) begin
            prev_we = we;
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", maxc);
        end
    endtask

    // Byte driver: offers the queue head, pops it once the handshake completed.
    initial begin
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (acc_pend && tx_q.size() > 0) begin
                tx_q.delete(0);
            end
            phase = ~phase;
            if (tx_q.size() > 0 && (!toggle_mode || phase)) begin
                byte_valid = 1'b1;
                byte_data  = tx_q[0];
            end else begin
                byte_valid = 1'b0;
            end
            acc_pend = byte_valid && byte_ready && rst;
        end
    end

    // Monitor: every write strobe must match the next expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && we === 1'b1) begin
                we_cnt++;
                check("ready_low_in_write", 32'(byte_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_we: got write addr=0x%0h data=0x%0h expected none", waddr, wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("waddr", 32'(waddr), 32'(mon_e.addr));
                    check("wdata", wdata, mon_e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         we0;
        int         n;
        logic       pw;
        logic [31:0] w;

        rst       = 1'b0;
        start     = 1'b0;
        len_words = '0;
        repeat (2) @(negedge clk);
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        rst = 1'b1;

        // Two words, valid always high: 10 cycles from start to done.
        push4(8'h13, 8'h00, 8'h40, 8'h20);
        push4(8'h08, 8'h00, 8'h00, 8'h0C);
        push_exp(10'd0, 32'h20400013);
        push_exp(10'd1, 32'h0C000008);
        we0 = we_cnt;
        do_start(11'd2);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_hold", 32'(cpu_hold), 32'd1);
        wait_done(50, cyc, pw);
        check("t1_cycles", 32'(cyc), 32'd10);
        check("t1_we_before_done", 32'(pw), 32'd1);
        check("t1_hold_released", 32'(cpu_hold), 32'd0);
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_writes", 32'(we_cnt - we0), 32'd2);
        check("t1_waddr_hold", 32'(waddr), 32'd1);
        check("t1_wdata_hold", wdata, 32'h0C000008);

        // Illegal lengths: from DONE with 0, then from IDLE with 1025.
        we0 = we_cnt;
        do_start(11'd0);
        check("t2_err", 32'(err), 32'd1);
        check("t2_done_cleared", 32'(done), 32'd0);
        check("t2_hold", 32'(cpu_hold), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        do_start(11'd1025);
        check("t2_err_1025", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        check("t2_busy_idle", 32'(busy), 32'd0);
        check("t2_ready_idle", 32'(byte_ready), 32'd0);
        check("t2_err_sticky", 32'(err), 32'd1);
        check("t2_no_we", 32'(we_cnt - we0), 32'd0);

        // One word with byte_valid toggling every other cycle.
        toggle_mode = 1'b1;
        push4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        push_exp(10'd0, 32'hDDCCBBAA);
        we0 = we_cnt;
        do_start(11'd1);
        check("t3_err_cleared", 32'(err), 32'd0);
        wait_done(100, cyc, pw);
        check("t3_writes", 32'(we_cnt - we0), 32'd1);
        check("t3_bytes_used", 32'(tx_q.size()), 32'd0);
        toggle_mode = 1'b0;

        // Start from DONE, then a stray illegal start while receiving.
        push4(8'h44, 8'h33, 8'h22, 8'h11);
        push4(8'h5A, 8'h5A, 8'hA5, 8'hA5);
        push_exp(10'd0, 32'h11223344);
        push_exp(10'd1, 32'hA5A55A5A);
        we0 = we_cnt;
        do_start(11'd2);
        check("t4_hold_raised", 32'(cpu_hold), 32'd1);
        check("t4_done_cleared", 32'(done), 32'd0);
        @(negedge clk);
        start     = 1'b1;
        len_words = 11'd0;
        @(negedge clk);
        start     = 1'b0;
        check("t4_err_ignored", 32'(err), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        wait_done(100, cyc, pw);
        check("t4_writes", 32'(we_cnt - we0), 32'd2);

        // Reset after two bytes of word 3, then a fresh load from address 0.
        push4(8'h04, 8'h03, 8'h02, 8'h01);
        push4(8'h10, 8'h20, 8'h30, 8'h40);
        push4(8'h55, 8'h66, 8'h77, 8'h88);
        tx_q.push_back(8'hEE);
        tx_q.push_back(8'hFF);
        push_exp(10'd0, 32'h01020304);
        push_exp(10'd1, 32'h40302010);
        push_exp(10'd2, 32'h88776655);
        we0 = we_cnt;
        do_start(11'd5);
        n = 0;
        while (tx_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_bytes_sent", 32'(tx_q.size()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_we", 32'(we), 32'd0);
        check("t5_waddr", 32'(waddr), 32'd0);
        check("t5_wdata", wdata, 32'd0);
        check("t5_ready", 32'(byte_ready), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_err", 32'(err), 32'd0);
        check("t5_hold", 32'(cpu_hold), 32'd1);
        check("t5_pending_exp", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_writes", 32'(we_cnt - we0), 32'd3);
        push4(8'hC0, 8'hFF, 8'hEE, 8'h01);
        push_exp(10'd0, 32'h01EEFFC0);
        do_start(11'd1);
        wait_done(50, cyc, pw);
        check("t5_reload_writes", 32'(we_cnt - we0), 32'd4);

        // Full 1024-word load with random content.
        for (int i = 0; i < 1024; i++) begin
            w = $urandom();
            push4(w[7:0], w[15:8], w[23:16], w[31:24]);
            push_exp(10'(i), w);
        end
        we0 = we_cnt;
        do_start(11'd1024);
        wait_done(6000, cyc, pw);
        check("t6_writes", 32'(we_cnt - we0), 32'd1024);
        check("t6_last_addr", 32'(waddr), 32'd1023);
        check("t6_hold", 32'(cpu_hold), 32'd0);

        repeat (3) @(negedge clk);
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the instruction-memory word-address width (1024 words, 4 KB).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle request to begin a load.
REQ-005 The block SHALL have port len_words, input, ADDR_W+1 bits: the number of 32-bit words to load, sampled when start is accepted.
REQ-006 The block SHALL have port byte_valid, input, 1 bit: the upstream byte stream holds valid data.
REQ-007 The block SHALL have port byte_data, input, 8 bits: the upstream byte.
REQ-008 The block SHALL have port byte_ready, output, 1 bit: the loader can accept a byte.
REQ-009 The block SHALL have port we, output, 1 bit: the instruction-memory write strobe.
REQ-010 The block SHALL have port waddr, output, ADDR_W bits: the instruction-memory word address.
REQ-011 The block SHALL have port wdata, output, 32 bits: the instruction word to write.
REQ-012 The block SHALL have port cpu_hold, output, 1 bit: while high, the fetch unit's PC is held in reset.
REQ-013 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: the last load completed.
REQ-015 The block SHALL have port err, output, 1 bit: the last start carried an illegal length.

Function
REQ-016 The FSM SHALL have the states IDLE, RECV, WRITE and DONE.
REQ-017 A byte SHALL be accepted only on a cycle where byte_valid and byte_ready are both high.
REQ-018 byte_ready SHALL be high only in RECV and SHALL be a function of state only, not of byte_valid.
REQ-019 Word assembly SHALL be little-endian: accepted byte k of a word (k = 0..3) goes to wdata bits [8k+7:8k].
REQ-020 A byte counter (2 bits) SHALL count accepted bytes; on the 4th accepted byte the FSM SHALL go RECV->WRITE and the counter SHALL wrap to 0.
REQ-021 In WRITE, for exactly one cycle: we=1, waddr=word_cnt, wdata=assembled word, byte_ready=0.
REQ-022 Latency from the 4th byte accept to we high SHALL be 1 cycle, so the minimum is 5 cycles per word.
REQ-023 In WRITE, if word_cnt+1 == len_q the FSM SHALL go to DONE; otherwise word_cnt SHALL increment and the FSM SHALL go to RECV.
REQ-024 When outside WRITE, we SHALL be 0, and waddr/wdata SHALL hold their last values.
REQ-025 In IDLE, start with 1 <= len_words <= 2^ADDR_W SHALL latch len_q, clear word_cnt, the byte counter, done and err, and enter RECV.
REQ-026 In IDLE, start with len_words == 0 or > 2^ADDR_W SHALL set err=1 and clear done; the FSM SHALL remain in IDLE.
REQ-027 err SHALL stay high until the next start.
REQ-028 In DONE: done=1, cpu_hold=0, busy=0.
REQ-029 In DONE, a legal start SHALL behave as in IDLE, clear done, and raise cpu_hold on the next cycle.
REQ-030 In DONE, an illegal start SHALL set err, clear done, and move to IDLE with cpu_hold=1.
REQ-031 start asserted in RECV or WRITE SHALL be ignored.
REQ-032 busy SHALL be 1 exactly in RECV and WRITE.
REQ-033 cpu_hold SHALL be 1 in IDLE, RECV and WRITE.
REQ-034 A write SHALL never be issued for word_cnt >= len_q, and a load of 2^ADDR_W words SHALL end with a last write at waddr = 2^ADDR_W-1 without wrapping.
REQ-035 A byte presented during WRITE SHALL be held upstream (ready=0) and accepted in the following RECV cycle.

Reset
REQ-036 When rst=0 at a clk edge, the block SHALL enter IDLE with word_cnt=0, byte counter=0, len_q=0, we=0, waddr=0, wdata=0, byte_ready=0, busy=0, done=0, err=0, cpu_hold=1.
REQ-037 rst=0 mid-load SHALL abort immediately with no further we pulses, and the partial word SHALL be discarded.

Verification
REQ-038 The bench SHALL cover: start with len=2; bytes 0x13,0x00,0x40,0x20 then 0x08,0x00,0x00,0x0C with valid always high -> we at addr 0 with 0x20400013, then at addr 1 with 0x0C000008; done=1 and cpu_hold=0 on the cycle after the second write; 10 cycles total.
REQ-039 The bench SHALL cover: len=1 with byte_valid toggling every other cycle -> exactly one we, data correct, and no byte accepted while ready=0.
REQ-040 The bench SHALL cover: start with len=0 and separately len=1025 -> err=1, the FSM stays in IDLE, and no we pulses.
REQ-041 The bench SHALL cover: len=1024 with random bytes -> 1024 writes at addresses 0..1023 in order, then done; a scoreboard matches every word.
REQ-042 The bench SHALL cover: rst=0 after 2 bytes of word 3 -> all outputs at reset values next cycle, and a fresh start reloads from addr 0.
REQ-043 The bench SHALL cover: start pulsed during RECV -> ignored, with the in-progress load completing unchanged.
